// File: rtl/dmem_tx_serializer.sv
// dmem_tx_serializer: drains an inclusive data-memory address range to the UART TX, LSB byte first.
// Optional DMEM_TX_CHECKSUM_EN appends an XOR checksum byte after the last data byte.
module dmem_tx_serializer #(
    parameter int MEM_WORD_LENGTH = 48,
    parameter int MEM_DEPTH = 4096,
    parameter int UART_WIDTH = 8,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       txStartN,
    input  logic [ADDR_WIDTH-1:0]      start_addr,
    input  logic [ADDR_WIDTH-1:0]      end_addr,
    output logic [ADDR_WIDTH-1:0]      mem_address,
    input  logic [MEM_WORD_LENGTH-1:0] dataFromMem,
    input  logic                       txByteReady,
    output logic                       txByteStart,
    output logic [UART_WIDTH-1:0]      byteForTx,
    output logic                       busy,
    output logic                       mem_transmitted
);
    localparam int BYTES_PER_WORD = (MEM_WORD_LENGTH + UART_WIDTH - 1) / UART_WIDTH;
    localparam int SHIFT_W = BYTES_PER_WORD * UART_WIDTH;
    localparam int CNT_W = $clog2(BYTES_PER_WORD + 1);

    typedef enum logic [2:0] {
        IDLE, MEM_WAIT, LOAD, WAIT_RDY, SEND, WAIT_ACK, DONE
`ifdef DMEM_TX_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    state_t state;
    logic [SHIFT_W-1:0] shift;
    logic [CNT_W-1:0] byteCnt;
    logic [ADDR_WIDTH-1:0] endAddr;
    logic [ADDR_WIDTH-1:0] nextAddr;
`ifdef DMEM_TX_CHECKSUM_EN
    logic [UART_WIDTH-1:0] chk;
    logic sendingChk;
`endif

    // Wrap explicitly so non-power-of-two depths still cycle through MEM_DEPTH-1 -> 0
    assign nextAddr = (mem_address == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : mem_address + ADDR_WIDTH'(1);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
            shift <= '0;
            byteCnt <= '0;
            endAddr <= '0;
            mem_address <= '0;
            txByteStart <= 1'b0;
            byteForTx <= '0;
            busy <= 1'b0;
            mem_transmitted <= 1'b0;
`ifdef DMEM_TX_CHECKSUM_EN
            chk <= '0;
            sendingChk <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (!txStartN) begin
                    endAddr <= end_addr;
                    mem_address <= start_addr;
                    busy <= 1'b1;
                    state <= MEM_WAIT;
`ifdef DMEM_TX_CHECKSUM_EN
                    chk <= '0;
                    sendingChk <= 1'b0;
`endif
                end
                MEM_WAIT: state <= LOAD;
                LOAD: begin
                    shift <= SHIFT_W'(dataFromMem);
                    byteCnt <= '0;
                    state <= WAIT_RDY;
                end
                WAIT_RDY: if (txByteReady) begin
                    byteForTx <= shift[UART_WIDTH-1:0];
                    txByteStart <= 1'b1;
                    state <= SEND;
                end
                SEND: begin
                    txByteStart <= 1'b0;
                    state <= WAIT_ACK;
`ifdef DMEM_TX_CHECKSUM_EN
                    chk <= chk ^ byteForTx;
`endif
                end
                // Ready falling is the UART's acceptance of the byte just launched
                WAIT_ACK: if (!txByteReady) begin
`ifdef DMEM_TX_CHECKSUM_EN
                    if (sendingChk) begin
                        busy <= 1'b0;
                        mem_transmitted <= 1'b1;
                        state <= DONE;
                    end else
`endif
                    if (byteCnt < CNT_W'(BYTES_PER_WORD - 1)) begin
                        shift <= shift >> UART_WIDTH;
                        byteCnt <= byteCnt + CNT_W'(1);
                        state <= WAIT_RDY;
                    end else if (mem_address == endAddr) begin
`ifdef DMEM_TX_CHECKSUM_EN
                        state <= CHK;
`else
                        busy <= 1'b0;
                        mem_transmitted <= 1'b1;
                        state <= DONE;
`endif
                    end else begin
                        mem_address <= nextAddr;
                        state <= MEM_WAIT;
                    end
                end
                DONE: if (txStartN) begin
                    mem_transmitted <= 1'b0;
                    state <= IDLE;
                end
`ifdef DMEM_TX_CHECKSUM_EN
                CHK: begin
                    shift <= SHIFT_W'(chk);
                    sendingChk <= 1'b1;
                    state <= WAIT_RDY;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_tx_serializer.sv
// tb_dmem_tx_serializer: randomized scoreboard bench with a RAM and UART model around dmem_tx_serializer.
// Build with DMEM_TX_CHECKSUM_EN defined to expect the trailing checksum byte.
module tb_dmem_tx_serializer;
    localparam int DEPTH = 16;

    typedef struct {
        logic [7:0] b;
        logic [3:0] a;
    } exp_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic txStartN = 1'b1;
    logic [3:0] start_addr = '0;
    logic [3:0] end_addr = '0;
    logic [3:0] mem_address;
    logic [47:0] dataFromMem = '0;
    logic txByteReady;
    logic txByteStart;
    logic [7:0] byteForTx;
    logic busy;
    logic mem_transmitted;

    logic [47:0] mem [DEPTH];
    exp_t expQ [$];
    exp_t got;
    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    logic uartRdy = 1'b1;
    logic stall = 1'b0;
    int lowCnt = 0;
    logic haveLast = 1'b0;
    logic [7:0] lastByte = '0;

    dmem_tx_serializer #(.MEM_WORD_LENGTH(48), .MEM_DEPTH(DEPTH), .UART_WIDTH(8)) dut (
        .clk(clk),
        .rstN(rstN),
        .txStartN(txStartN),
        .start_addr(start_addr),
        .end_addr(end_addr),
        .mem_address(mem_address),
        .dataFromMem(dataFromMem),
        .txByteReady(txByteReady),
        .txByteStart(txByteStart),
        .byteForTx(byteForTx),
        .busy(busy),
        .mem_transmitted(mem_transmitted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) dataFromMem <= mem[mem_address];

    // UART: drops ready for 8..12 cycles after each launch pulse
    assign txByteReady = uartRdy && !stall;
    always @(posedge clk) begin
        if (txByteStart) begin
            uartRdy <= 1'b0;
            lowCnt <= $urandom_range(12, 8);
        end else if (lowCnt > 1) begin
            lowCnt <= lowCnt - 1;
        end else if (lowCnt == 1) begin
            lowCnt <= 0;
            uartRdy <= 1'b1;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rstN) begin
            haveLast = 1'b0;
        end else if (txByteStart) begin
            pulses++;
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: got byte %0h expected no pulse at %0t", byteForTx, $time);
            end else begin
                got = expQ.pop_front();
                check("tx_byte", byteForTx, got.b);
                check("tx_addr", mem_address, got.a);
            end
            check("ready_at_pulse", uartRdy, 1);
            lastByte = byteForTx;
            haveLast = 1'b1;
        end else if (haveLast) begin
            check("byte_stable", byteForTx, lastByte);
        end
    end

    function automatic void pushExp(input int s, input int e);
        int words;
        logic [7:0] x;
        exp_t t;
        words = ((e - s + DEPTH) % DEPTH) + 1;
        x = '0;
        for (int w = 0; w < words; w++) begin
            int a;
            a = (s + w) % DEPTH;
            for (int b = 0; b < 6; b++) begin
                t.b = mem[a][8*b +: 8];
                t.a = 4'(a);
                expQ.push_back(t);
                x ^= t.b;
            end
        end
`ifdef DMEM_TX_CHECKSUM_EN
        t.b = x;
        t.a = 4'(e);
        expQ.push_back(t);
`endif
    endfunction

    task automatic startXfer(input int s, input int e, input bit hold);
        start_addr = 4'(s);
        end_addr = 4'(e);
        pushExp(s, e);
        @(negedge clk);
        txStartN = 1'b0;
        if (!hold) begin
            @(negedge clk);
            txStartN = 1'b1;
        end
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (!mem_transmitted && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", mem_transmitted, 1);
        check("busy_in_done", busy, 0);
        check("queue_drained", expQ.size(), 0);
    endtask

    task automatic xfer(input int s, input int e);
        startXfer(s, e, 0);
        waitDone();
        @(negedge clk);
        check("back_to_idle", mem_transmitted, 0);
    endtask

    task automatic checkResetOutputs();
        check("rst_addr", mem_address, 0);
        check("rst_start", txByteStart, 0);
        check("rst_byte", byteForTx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", mem_transmitted, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        for (int k = 0; k < DEPTH; k++) mem[k] = {6{8'(k)}};
        mem[5] = 48'h0A0B0C0D0E0F;
        repeat (3) @(negedge clk);
        checkResetOutputs();
        rstN = 1'b1;
        @(negedge clk);

        xfer(5, 5);
        mem[5] = {6{8'h05}};
        xfer(5, 8);
        xfer(14, 1);

        // Ready held low before the first byte; mid-transfer start and address changes must be ignored
        stall = 1'b1;
        base = pulses;
        startXfer(2, 3, 0);
        repeat (200) @(negedge clk);
        check("stall_no_pulse", pulses, base);
        check("stall_busy", busy, 1);
        stall = 1'b0;
        n = 0;
        while (pulses < base + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("two_bytes_after_stall", pulses >= base + 2, 1);
        txStartN = 1'b0;
        start_addr = 4'($urandom_range(15));
        end_addr = 4'($urandom_range(15));
        @(negedge clk);
        txStartN = 1'b1;
        waitDone();
        @(negedge clk);

        // Start held low through completion must not retrigger
        startXfer(9, 9, 1);
        waitDone();
        base = pulses;
        repeat (5) @(negedge clk);
        check("done_hold", mem_transmitted, 1);
        check("done_hold_no_pulse", pulses, base);
        txStartN = 1'b1;
        @(negedge clk);
        check("done_release", mem_transmitted, 0);

        // Abort with async reset after the 3rd byte
        base = pulses;
        startXfer(3, 4, 0);
        n = 0;
        while (pulses < base + 3 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("third_byte_seen", pulses >= base + 3, 1);
        #2 rstN = 1'b0;
        #1 checkResetOutputs();
        expQ.delete();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        base = pulses;
        repeat (50) @(negedge clk);
        check("no_pulse_after_reset", pulses, base);
        check("idle_after_reset", busy, 0);
        xfer(3, 4);

        mem[0] = 48'h0102_0304_0506;
        xfer(0, 0);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < DEPTH; k++) mem[k] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            xfer($urandom_range(15), $urandom_range(15));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
